// File: rtl/td4_pkg.sv
// Shared definitions for the TD4 program loader: default widths, loader FSM
// states and the NOP encoding used to pad unloaded program words.
package td4_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 8;

  localparam logic [7:0] NOP = 8'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage : td4_pkg

// File: rtl/prog_ram.sv
// Writable program memory: one synchronous write port, one combinational read
// port, every word cleared by the asynchronous reset.
module prog_ram
  import td4_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Flop-based storage: a block RAM cannot clear all words on reset.
  logic [DATA_W-1:0] word_q [DEPTH];

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        word_q[i] <= '0;
      end
    end else if (we_i) begin
      word_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = word_q[raddr_i];

endmodule : prog_ram

// File: rtl/prog_loader.sv
// Host-driven program loader: streams instruction bytes into program memory
// while holding the CPU, zero-pads the unloaded tail and reports the byte count.
module prog_loader
  import td4_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              host_start,
  input  logic              host_valid,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  input  logic              host_end,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W:0]   load_count_q;

  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  prog_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_prog_ram (
    .clk     (clk),
    .rst_ni  (n_reset),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (ram_wdata),
    .raddr_i (cpu_addr),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      load_count_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      // DONE lasts one cycle, so this captures the final count exactly once.
      if (state_d == DONE) begin
        load_count_q <= count_d;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    ram_we     = 1'b0;
    ram_wdata  = host_data;
    host_ready = 1'b0;
    load_done  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (host_start) begin
          state_d  = LOAD;
          wr_ptr_d = '0;
          count_d  = '0;
        end
      end

      LOAD: begin
        host_ready = 1'b1;
        if (host_valid) begin
          ram_we  = 1'b1;
          count_d = count_q + (ADDR_W + 1)'(1);
          if (wr_ptr_q == LAST_ADDR) begin
            state_d = DONE;
          end else begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          end
        end
        // A byte accepted alongside host_end is already in wr_ptr_d.
        if (host_end && state_d == LOAD) begin
          state_d = (wr_ptr_d < LAST_ADDR) ? FILL : DONE;
        end
      end

      FILL: begin
        ram_we    = 1'b1;
        ram_wdata = DATA_W'(NOP);
        if (wr_ptr_q == LAST_ADDR) begin
          state_d = DONE;
        end else begin
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
      end

      DONE: begin
        load_done = 1'b1;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cpu_hold   = (state_q != IDLE);
  assign cpu_dout   = (state_q == IDLE) ? ram_rdata : '0;
  assign load_count = load_count_q;

endmodule : prog_loader

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: reset sweep table, full/short/stalled
// load sessions with a write scoreboard, ignored-control cases and mid-load reset.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       host_start, host_valid, host_end;
  logic [7:0] host_data;
  logic       host_ready;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_dout;
  logic       cpu_hold, load_done;
  logic [4:0] load_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected memory contents in address order, pushed as bytes are driven.
  logic [7:0] exp_q[$];

  typedef struct {
    logic [3:0] addr;
    logic [7:0] dout;
    logic       hold;
  } sweep_vec_t;

  sweep_vec_t zero_vec [16];

  prog_loader dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .host_start (host_start),
    .host_valid (host_valid),
    .host_data  (host_data),
    .host_ready (host_ready),
    .host_end   (host_end),
    .cpu_addr   (cpu_addr),
    .cpu_dout   (cpu_dout),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_count (load_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", name, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_sweep(input string tag);
    for (int i = 0; i < 16; i++) begin
      cpu_addr = zero_vec[i].addr;
      #1;
      check($sformatf("%s dout[%0d]", tag, i), 32'(cpu_dout), 32'(zero_vec[i].dout));
      check($sformatf("%s hold[%0d]", tag, i), 32'(cpu_hold), 32'(zero_vec[i].hold));
    end
  endtask

  task automatic scoreboard_sweep(input string tag);
    check({tag, " queue depth"}, 32'(exp_q.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp_b;
      exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
      cpu_addr = 4'(i);
      #1;
      check($sformatf("%s mem[%0d]", tag, i), 32'(cpu_dout), 32'(exp_b));
    end
  endtask

  task automatic start_session(input logic with_end);
    host_start = 1'b1;
    host_end   = with_end;
    check("hold before start edge", 32'(cpu_hold), 32'd0);
    tick();
    host_start = 1'b0;
    host_end   = 1'b0;
    check("hold rises after start", 32'(cpu_hold), 32'd1);
    check("ready in LOAD", 32'(host_ready), 32'd1);
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (!load_done && cycles < budget) begin
      tick();
      cycles++;
      if (!load_done) check("hold during wait", 32'(cpu_hold), 32'd1);
    end
    check("load_done within budget", 32'(load_done), 32'd1);
  endtask

  initial begin
    int cyc;
    int accepted;

    for (int i = 0; i < 16; i++) begin
      zero_vec[i].addr = 4'(i);
      zero_vec[i].dout = 8'h00;
      zero_vec[i].hold = 1'b0;
    end

    n_reset = 1'b0; host_start = 1'b0; host_valid = 1'b0; host_end = 1'b0;
    host_data = 8'h00; cpu_addr = 4'd0;
    #13;
    check("reset hold", 32'(cpu_hold), 32'd0);
    check("reset ready", 32'(host_ready), 32'd0);
    check("reset done", 32'(load_done), 32'd0);
    check("reset count", 32'(load_count), 32'd0);
    n_reset = 1'b1;
    tick();
    zero_sweep("post-reset");

    // Full 16-byte stream, valid every cycle.
    start_session(1'b0);
    for (int i = 0; i < 16; i++) begin
      host_valid = 1'b1;
      host_data  = 8'hB0 + 8'(i);
      check($sformatf("full ready[%0d]", i), 32'(host_ready), 32'd1);
      check($sformatf("full no early done[%0d]", i), 32'(load_done), 32'd0);
      check($sformatf("full dout held[%0d]", i), 32'(cpu_dout), 32'd0);
      exp_q.push_back(host_data);
      tick();
    end
    host_valid = 1'b0;
    check("full done after last write", 32'(load_done), 32'd1);
    check("full count", 32'(load_count), 32'd16);
    check("full hold in DONE", 32'(cpu_hold), 32'd1);
    check("full ready in DONE", 32'(host_ready), 32'd0);
    tick();
    check("full done one cycle", 32'(load_done), 32'd0);
    check("full hold falls", 32'(cpu_hold), 32'd0);
    cpu_addr = 4'd2;
    #1;
    check("full addr2", 32'(cpu_dout), 32'hB2);
    scoreboard_sweep("full");

    // Short session: host_end with the third byte, tail zero-filled.
    start_session(1'b0);
    for (int i = 0; i < 3; i++) begin
      logic [23:0] bytes;
      bytes = 24'hBFB0F0;
      host_valid = 1'b1;
      host_data  = bytes[23 - 8*i -: 8];
      host_end   = (i == 2);
      exp_q.push_back(host_data);
      tick();
    end
    host_valid = 1'b0;
    host_end   = 1'b0;
    check("short ready in FILL", 32'(host_ready), 32'd0);
    for (int i = 3; i < 16; i++) exp_q.push_back(8'h00);
    wait_done(40, cyc);
    check("short fill cycles", 32'(cyc), 32'd13);
    check("short count", 32'(load_count), 32'd3);
    tick();
    scoreboard_sweep("short");

    // Controls in IDLE that must be ignored (host_end, host_valid).
    host_end = 1'b1; host_valid = 1'b1; host_data = 8'hFF;
    tick();
    host_end = 1'b0; host_valid = 1'b0;
    check("idle end: hold", 32'(cpu_hold), 32'd0);
    check("idle end: done", 32'(load_done), 32'd0);
    check("idle end: count kept", 32'(load_count), 32'd3);
    cpu_addr = 4'd0;
    #1;
    check("idle valid no write", 32'(cpu_dout), 32'hBF);

    // Stalled session started with host_start+host_end together; host_start
    // repeated mid-load must not rewind the pointer.
    start_session(1'b1);
    accepted = 0;
    cyc = 0;
    while (accepted < 16 && cyc < 64) begin
      host_valid = cyc[0] ? 1'b0 : 1'b1;
      host_data  = host_valid ? (8'h5A ^ 8'(accepted * 7)) : 8'hEE;
      host_start = (cyc == 5);
      cpu_addr   = 4'd0;
      #1;
      check($sformatf("stall hold[%0d]", cyc), 32'(cpu_hold), 32'd1);
      check($sformatf("stall dout[%0d]", cyc), 32'(cpu_dout), 32'd0);
      if (host_valid) begin
        exp_q.push_back(host_data);
        accepted++;
      end
      tick();
      cyc++;
    end
    host_valid = 1'b0; host_start = 1'b0;
    check("stall done", 32'(load_done), 32'd1);
    check("stall count", 32'(load_count), 32'd16);
    tick();
    scoreboard_sweep("stall");

    // Reset mid-load after five bytes.
    start_session(1'b0);
    for (int i = 0; i < 5; i++) begin
      host_valid = 1'b1;
      host_data  = 8'hC0 + 8'(i);
      tick();
    end
    host_valid = 1'b0;
    #2;
    n_reset = 1'b0;
    #1;
    check("abort hold", 32'(cpu_hold), 32'd0);
    check("abort ready", 32'(host_ready), 32'd0);
    check("abort count", 32'(load_count), 32'd0);
    zero_sweep("abort");
    n_reset = 1'b1;
    tick();
    zero_sweep("after abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_prog_loader
